// File: rtl/l2cache_wb.sv
// l2cache_wb: write-back, write-allocate, NWAYS-way set-associative L2 cache.
//
// Sits between line-wide (NFU*32-bit) L1/fetch requests and a 64-bit
// main-memory port. Misses fill the line in BEATS = NFU/2 beats. A dirty
// victim is written back first. Every main-memory beat is held until mainAck.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   address          request byte address (line offset bits ignored)
//   doFetch/doWrite  line read / full-line write request (both high = write)
//   writeData        line data for doWrite
//   doneFetch        one-cycle completion pulse; data valid with it on reads
//   data             read line
//   doMainFetch      main read beat request  (mainAddress, mainData, mainAck)
//   doMainWrite      main write beat request (mainAddress, mainDataWrite, mainAck)
//
// Optional feature (macro L2CACHE_STATS_EN): adds statsClear input and
// saturating 32-bit hitCount / missCount outputs.
module l2cache_wb #(
  parameter int NFU            = 2,
  parameter int NSETS          = 1024,
  parameter int NWAYS          = 2,
  parameter int ADDRESS_LENGTH = 56
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDRESS_LENGTH-1:0] address,
  input  logic                      doFetch,
  input  logic                      doWrite,
  input  logic [NFU*32-1:0]         writeData,
  output logic                      doneFetch,
  output logic [NFU*32-1:0]         data,
  output logic                      doMainFetch,
  output logic                      doMainWrite,
  output logic [ADDRESS_LENGTH-1:0] mainAddress,
  output logic [63:0]               mainDataWrite,
  input  logic [63:0]               mainData,
  input  logic                      mainAck
`ifdef L2CACHE_STATS_EN
  ,
  input  logic                      statsClear,
  output logic [31:0]               hitCount,
  output logic [31:0]               missCount
`endif
);

  localparam int LINEW      = NFU * 32;
  localparam int LINEBYTES  = NFU * 4;
  localparam int OFFSETBITS = $clog2(LINEBYTES);
  localparam int SETBITS    = $clog2(NSETS);
  localparam int TAGSIZE    = ADDRESS_LENGTH - SETBITS - OFFSETBITS;
  localparam int BEATS      = NFU / 2;
  localparam int BCW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAYW       = (NWAYS > 1) ? $clog2(NWAYS) : 1;
  localparam int LINEADDR   = ADDRESS_LENGTH - OFFSETBITS;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, FILL, RESPOND
  } state_t;

  state_t state_q, state_d;

  logic [LINEADDR-1:0] laddr_q, laddr_d;
  logic [LINEW-1:0]    wdata_q, wdata_d;
  logic                is_write_q, is_write_d;
  logic [BCW-1:0]      beat_q, beat_d;
  logic [WAYW-1:0]     victim_q, victim_d;
  logic [TAGSIZE-1:0]  vtag_q, vtag_d;
  logic [LINEW-1:0]    vline_q, vline_d;
  logic [LINEW-1:0]    fill_q, fill_d;
  logic [LINEW-1:0]    data_q, data_d;
  logic                install_q, install_d;

  logic [TAGSIZE-1:0] tag_mem  [NWAYS][NSETS];
  logic [LINEW-1:0]   line_mem [NWAYS][NSETS];
  logic [NWAYS-1:0]   valid_q  [NSETS];
  logic [NWAYS-1:0]   dirty_q  [NSETS];
  logic [WAYW-1:0]    rr_q     [NSETS];

  logic [SETBITS-1:0] set_idx;
  logic [TAGSIZE-1:0] req_tag;
  logic               hit, inv_found;
  logic [WAYW-1:0]    hit_way, inv_way, victim_sel, rr_next;
  logic               beat_last;
  logic [ADDRESS_LENGTH-1:0] beat_off, req_base, wb_base;
  logic [LINEW-1:0]   fill_merged;

  logic               mem_we, vd_we, vd_dirty, dirty_clr, rr_adv;
  logic [WAYW-1:0]    mem_way;
  logic [LINEW-1:0]   mem_line;

  logic unused_addr_bits;
  assign unused_addr_bits = ^address[OFFSETBITS-1:0];

  assign set_idx   = laddr_q[SETBITS-1:0];
  assign req_tag   = laddr_q[LINEADDR-1 -: TAGSIZE];
  assign beat_last = (beat_q == BCW'(BEATS - 1));
  assign beat_off  = ADDRESS_LENGTH'({beat_q, 3'b000});
  assign req_base  = {laddr_q, {OFFSETBITS{1'b0}}};
  assign wb_base   = {vtag_q, set_idx, {OFFSETBITS{1'b0}}};
  assign data      = data_q;

  // Tag compare across the set; also find the lowest-index invalid way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < NWAYS; w++) begin
      if (!hit && valid_q[set_idx][w] && (tag_mem[w][set_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAYW'(w);
      end
      if (!inv_found && !valid_q[set_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAYW'(w);
      end
    end
  end

  assign victim_sel = inv_found ? inv_way : rr_q[set_idx];
  assign rr_next    = (rr_q[set_idx] == WAYW'(NWAYS - 1)) ? '0 : rr_q[set_idx] + 1'b1;

  always_comb begin
    fill_merged = fill_q;
    fill_merged[{beat_q, 6'd0} +: 64] = mainData;
  end

  always_comb begin
    state_d       = state_q;
    laddr_d       = laddr_q;
    wdata_d       = wdata_q;
    is_write_d    = is_write_q;
    beat_d        = beat_q;
    victim_d      = victim_q;
    vtag_d        = vtag_q;
    vline_d       = vline_q;
    fill_d        = fill_q;
    data_d        = data_q;
    install_d     = install_q;
    mem_we        = 1'b0;
    mem_way       = victim_q;
    mem_line      = wdata_q;
    vd_we         = 1'b0;
    vd_dirty      = 1'b0;
    dirty_clr     = 1'b0;
    rr_adv        = 1'b0;
    doneFetch     = 1'b0;
    doMainFetch   = 1'b0;
    doMainWrite   = 1'b0;
    mainAddress   = '0;
    mainDataWrite = '0;

    unique case (state_q)
      IDLE: begin
        if (doFetch || doWrite) begin
          laddr_d    = address[ADDRESS_LENGTH-1:OFFSETBITS];
          wdata_d    = writeData;
          is_write_d = doWrite;
          state_d    = LOOKUP;
        end
      end

      LOOKUP: begin
        if (install_q) begin
          // Second pass after a dirty writeback on a write miss: the victim
          // way is already chosen, so install without re-running replacement.
          mem_we    = 1'b1;
          vd_we     = 1'b1;
          vd_dirty  = 1'b1;
          install_d = 1'b0;
          state_d   = RESPOND;
        end else if (hit) begin
          if (is_write_q) begin
            mem_we   = 1'b1;
            mem_way  = hit_way;
            vd_we    = 1'b1;
            vd_dirty = 1'b1;
          end else begin
            data_d = line_mem[hit_way][set_idx];
          end
          state_d = RESPOND;
        end else begin
          rr_adv   = 1'b1;
          victim_d = victim_sel;
          vtag_d   = tag_mem[victim_sel][set_idx];
          vline_d  = line_mem[victim_sel][set_idx];
          beat_d   = '0;
          if (valid_q[set_idx][victim_sel] && dirty_q[set_idx][victim_sel]) begin
            state_d = WRITEBACK;
          end else if (!is_write_q) begin
            state_d = FILL;
          end else begin
            mem_we   = 1'b1;
            mem_way  = victim_sel;
            vd_we    = 1'b1;
            vd_dirty = 1'b1;
            state_d  = RESPOND;
          end
        end
      end

      WRITEBACK: begin
        doMainWrite   = 1'b1;
        mainAddress   = wb_base + beat_off;
        mainDataWrite = vline_q[{beat_q, 6'd0} +: 64];
        if (mainAck) begin
          if (beat_last) begin
            beat_d    = '0;
            dirty_clr = 1'b1;
            if (is_write_q) begin
              install_d = 1'b1;
              state_d   = LOOKUP;
            end else begin
              state_d = FILL;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      FILL: begin
        doMainFetch = 1'b1;
        mainAddress = req_base + beat_off;
        if (mainAck) begin
          fill_d = fill_merged;
          if (beat_last) begin
            beat_d   = '0;
            mem_we   = 1'b1;
            mem_line = fill_merged;
            vd_we    = 1'b1;
            vd_dirty = 1'b0;
            data_d   = fill_merged;
            state_d  = RESPOND;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      RESPOND: begin
        doneFetch = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      laddr_q    <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      beat_q     <= '0;
      victim_q   <= '0;
      vtag_q     <= '0;
      vline_q    <= '0;
      fill_q     <= '0;
      data_q     <= '0;
      install_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      laddr_q    <= laddr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      beat_q     <= beat_d;
      victim_q   <= victim_d;
      vtag_q     <= vtag_d;
      vline_q    <= vline_d;
      fill_q     <= fill_d;
      data_q     <= data_d;
      install_q  <= install_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (vd_we) begin
        valid_q[set_idx][mem_way] <= 1'b1;
        dirty_q[set_idx][mem_way] <= vd_dirty;
      end else if (dirty_clr) begin
        dirty_q[set_idx][victim_q] <= 1'b0;
      end
      if (rr_adv) begin
        rr_q[set_idx] <= rr_next;
      end
    end
  end

  // Line and tag storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      line_mem[mem_way][set_idx] <= mem_line;
      tag_mem[mem_way][set_idx]  <= req_tag;
    end
  end

`ifdef L2CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        count_hit, count_miss;

  assign count_hit  = (state_q == LOOKUP) && !install_q && hit;
  assign count_miss = (state_q == LOOKUP) && !install_q && !hit;
  assign hitCount   = hit_cnt_q;
  assign missCount  = miss_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (statsClear) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (count_hit && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (count_miss && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2cache_wb.sv
// Scoreboard bench for l2cache_wb (NFU=4, NSETS=16, NWAYS=2).
// Requests push expected responses; a monitor checks doneFetch/data/latency,
// and a main-memory responder checks every write-back and fetch beat.
module tb_l2cache_wb;

  localparam int NFU   = 4;
  localparam int NSETS = 16;
  localparam int NWAYS = 2;
  localparam int AL    = 56;

  typedef struct {
    logic [127:0] data;
    bit           chk;
    int           lat;
    int           issue;
    int           id;
  } exp_t;

  typedef struct {
    logic [AL-1:0] a;
    logic [63:0]   d;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [AL-1:0]  address = '0;
  logic           doFetch = 1'b0;
  logic           doWrite = 1'b0;
  logic [127:0]   writeData = '0;
  logic           doneFetch;
  logic [127:0]   data;
  logic           doMainFetch;
  logic           doMainWrite;
  logic [AL-1:0]  mainAddress;
  logic [63:0]    mainDataWrite;
  logic [63:0]    mainData = '0;
  logic           mainAck = 1'b0;
`ifdef L2CACHE_STATS_EN
  logic           statsClear = 1'b0;
  logic [31:0]    hitCount;
  logic [31:0]    missCount;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_until = 0;
  int req_id = 0;

  exp_t          sb_q[$];
  beat_t         wb_q[$];
  logic [AL-1:0] fetch_q[$];
  logic [63:0]   mem [logic [AL-1:0]];

  exp_t  mon_e;
  beat_t rsp_b;
  bit    prev_done = 1'b0;

  l2cache_wb #(
    .NFU(NFU),
    .NSETS(NSETS),
    .NWAYS(NWAYS),
    .ADDRESS_LENGTH(AL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .doFetch(doFetch),
    .doWrite(doWrite),
    .writeData(writeData),
    .doneFetch(doneFetch),
    .data(data),
    .doMainFetch(doMainFetch),
    .doMainWrite(doMainWrite),
    .mainAddress(mainAddress),
    .mainDataWrite(mainDataWrite),
    .mainData(mainData),
    .mainAck(mainAck)
`ifdef L2CACHE_STATS_EN
    ,
    .statsClear(statsClear),
    .hitCount(hitCount),
    .missCount(missCount)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Completion monitor: every doneFetch must match the oldest outstanding request.
  always @(posedge clk) begin
    #1;
    if (reset && doneFetch) begin
      chk("done_expected", 128'(sb_q.size() != 0), 128'(1));
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) chk($sformatf("data_req%0d", mon_e.id), data, mon_e.data);
        if (mon_e.lat >= 0) chk($sformatf("lat_req%0d", mon_e.id), 128'(cyc - mon_e.issue), 128'(mon_e.lat));
      end
    end
    if (prev_done) chk("done_one_pulse", 128'(doneFetch), 128'(0));
    prev_done = reset && doneFetch;
  end

  // Main-memory responder: acks each requested beat unless stalled.
  always @(negedge clk) begin
    if (reset && (doMainFetch || doMainWrite) && (cyc >= stall_until)) begin
      mainAck = 1'b1;
      if (doMainWrite) begin
        if (wb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wb actual_addr=%h required=none", mainAddress);
        end else begin
          rsp_b = wb_q.pop_front();
          chk("wb_addr", 128'(mainAddress), 128'(rsp_b.a));
          chk("wb_data", 128'(mainDataWrite), 128'(rsp_b.d));
        end
        mem[mainAddress] = mainDataWrite;
      end else begin
        chk("wb_before_fill", 128'(wb_q.size()), 128'(0));
        if (fetch_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_fetch actual_addr=%h required=none", mainAddress);
        end else begin
          chk("fetch_addr", 128'(mainAddress), 128'(fetch_q.pop_front()));
        end
        mainData = mem.exists(mainAddress) ? mem[mainAddress] : 64'h0;
      end
    end else begin
      mainAck = 1'b0;
    end
  end

  task automatic push_fetch(input logic [AL-1:0] a);
    fetch_q.push_back(a);
  endtask

  task automatic push_wb(input logic [AL-1:0] a, input logic [63:0] d);
    beat_t b;
    b.a = a;
    b.d = d;
    wb_q.push_back(b);
  endtask

  // Issue one request for one cycle, then wait (bounded) for its completion.
  task automatic req(input logic [AL-1:0] a, input bit f, input bit w,
                     input logic [127:0] wd, input logic [127:0] ed,
                     input bit ck, input int lat);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    address   = a;
    doFetch   = f;
    doWrite   = w;
    writeData = wd;
    e.data  = ed;
    e.chk   = ck;
    e.lat   = lat;
    e.issue = cyc;
    e.id    = req_id;
    req_id++;
    sb_q.push_back(e);
    @(posedge clk); #1;
    doFetch = 1'b0;
    doWrite = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout_req%0d actual=no_doneFetch required=doneFetch", e.id);
      sb_q.delete();
    end
    chk("beats_left", 128'(fetch_q.size() + wb_q.size()), 128'(0));
    fetch_q.delete();
    wb_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_doneFetch"}, 128'(doneFetch), 128'(0));
    chk({tag, "_doMainFetch"}, 128'(doMainFetch), 128'(0));
    chk({tag, "_doMainWrite"}, 128'(doMainWrite), 128'(0));
    chk({tag, "_data"}, data, 128'(0));
    chk({tag, "_mainAddress"}, 128'(mainAddress), 128'(0));
    chk({tag, "_mainDataWrite"}, 128'(mainDataWrite), 128'(0));
  endtask

  localparam logic [127:0] W1 = 128'h0123_4567_89AB_CDEF_0000_0000_0000_0055;
  localparam logic [127:0] W2 = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0;
  localparam logic [127:0] W3 = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111;
  localparam logic [127:0] W4 = 128'h4444_0000_4444_0000_4444_0000_4444_0000;
  localparam logic [127:0] W5 = 128'h5555_5555_5555_5555_6666_6666_6666_6666;
  localparam logic [127:0] W6 = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mem[56'h1000] = 64'h0000_0000_0000_000A;
    mem[56'h1008] = 64'h0000_0000_0000_000B;
    mem[56'h0110] = 64'h0000_0000_0000_0110;
    mem[56'h0118] = 64'h0000_0000_0000_0118;
    mem[56'h0210] = 64'h0000_0000_0000_0210;
    mem[56'h0218] = 64'h0000_0000_0000_0218;
    mem[56'h4060] = 64'h0000_0000_0000_4060;
    mem[56'h4068] = 64'h0000_0000_0000_4068;

    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    // Cold read miss, two beats.
    push_fetch(56'h1000);
    push_fetch(56'h1008);
    req(56'h1000, 1, 0, '0, 128'h0000_0000_0000_000B_0000_0000_0000_000A, 1, -1);
    // Reread hits, no main traffic.
    req(56'h1000, 1, 0, '0, 128'h0000_0000_0000_000B_0000_0000_0000_000A, 1, 2);

    // Write miss into an empty set: installs without main traffic.
    req(56'h0010, 0, 1, W1, '0, 0, 2);
    push_fetch(56'h0110);
    push_fetch(56'h0118);
    req(56'h0110, 1, 0, '0, 128'h0000_0000_0000_0118_0000_0000_0000_0110, 1, -1);
    // Set 1 full: round-robin picks way 0 (dirty 0x10) -> writeback then fill.
    push_wb(56'h0010, W1[63:0]);
    push_wb(56'h0018, W1[127:64]);
    push_fetch(56'h0210);
    push_fetch(56'h0218);
    req(56'h0210, 1, 0, '0, 128'h0000_0000_0000_0218_0000_0000_0000_0210, 1, -1);
    // Evicted line comes back from memory with the written-back data.
    push_fetch(56'h0010);
    push_fetch(56'h0018);
    req(56'h0010, 1, 0, '0, W1, 1, -1);

    req(56'h2040, 0, 1, W2, '0, 0, 2);
    req(56'h2040, 1, 0, '0, W2, 1, 2);

    // Write hit, then read back.
    req(56'h1000, 0, 1, W3, '0, 0, 2);
    req(56'h1000, 1, 0, '0, W3, 1, 2);

    // Write miss into invalid way 1, then a write miss evicting dirty way 0.
    req(56'h1100, 0, 1, W6, '0, 0, 2);
    push_wb(56'h1000, W3[63:0]);
    push_wb(56'h1008, W3[127:64]);
    req(56'h1200, 0, 1, W5, '0, 0, -1);
    req(56'h1200, 1, 0, '0, W5, 1, 2);
    req(56'h1100, 1, 0, '0, W6, 1, 2);

    // doFetch and doWrite together act as a write.
    req(56'h3050, 1, 1, W4, '0, 0, 2);
    req(56'h3050, 1, 0, '0, W4, 1, 2);

    // Stall mid-fill, then reset in the middle of the transaction.
    stall_until = 32'h7FFF_FFFF;
    @(posedge clk); #1;
    address = 56'h4060;
    doFetch = 1'b1;
    @(posedge clk); #1;
    doFetch = 1'b0;
    n = 0;
    while (!doMainFetch && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_reached_fill", 128'(doMainFetch), 128'(1));
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_fetch_held", 128'(doMainFetch), 128'(1));
      chk("stall_addr_held", 128'(mainAddress), 128'(56'h4060));
    end
    reset = 1'b0;
    #1;
    chk_outputs_zero("midfill_rst");
    sb_q.delete();
    fetch_q.delete();
    wb_q.delete();
    @(posedge clk);
    @(negedge clk);
    stall_until = 0;
    reset = 1'b1;
`ifdef L2CACHE_STATS_EN
    chk("stats_rst_hit", 128'(hitCount), 128'(0));
    chk("stats_rst_miss", 128'(missCount), 128'(0));
`endif

    // Cache contents lost: 0x1000 misses and returns the written-back line.
    push_fetch(56'h1000);
    push_fetch(56'h1008);
    req(56'h1000, 1, 0, '0, W3, 1, -1);
    push_fetch(56'h4060);
    push_fetch(56'h4068);
    req(56'h4060, 1, 0, '0, 128'h0000_0000_0000_4068_0000_0000_0000_4060, 1, -1);
    req(56'h1000, 1, 0, '0, W3, 1, 2);
    req(56'h4060, 1, 0, '0, 128'h0000_0000_0000_4068_0000_0000_0000_4060, 1, 2);
    req(56'h1000, 1, 0, '0, W3, 1, 2);

`ifdef L2CACHE_STATS_EN
    chk("stats_hits", 128'(hitCount), 128'(3));
    chk("stats_misses", 128'(missCount), 128'(2));
    @(posedge clk); #1;
    statsClear = 1'b1;
    @(posedge clk); #1;
    statsClear = 1'b0;
    chk("stats_clr_hit", 128'(hitCount), 128'(0));
    chk("stats_clr_miss", 128'(missCount), 128'(0));
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
